game_ctl: RTL and testbench

Game-flow sequencer for the VGA mouse game. Runs in the `pclk` domain after `cursor_sync`. Turns mouse clicks on on-screen buttons and the peer's UART ready pulse into the IDLE → WAIT → GAME → SCORE sequence. Owns the round countdown, the hit score and the text-box placement driven into `draw_rect_char`.

---
 rtl/game_pkg.sv | 24 ++
 rtl/region_click.sv | 35 +++
 rtl/game_ctl.sv | 161 ++++++++++++++++
 tb/tb_game_ctl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow sequencer.
package game_pkg;

  localparam int unsigned POS_W   = 12;
  localparam int unsigned SCORE_W = 10;
  localparam int unsigned SEC_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GAME  = 2'd2,
    ST_SCORE = 2'd3
  } state_e;

  localparam logic [SCORE_W-1:0] SCORE_MAX   = 10'd999;
  localparam logic [POS_W-1:0]   SCORE_BOX_X = 12'd380;
  localparam logic [POS_W-1:0]   SCORE_BOX_Y = 12'd186;

  // Saturating hit counter increment.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v >= SCORE_MAX) ? SCORE_MAX : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/region_click.sv
// Rising-edge click detector qualified by a fixed on-screen rectangle.
module region_click
  import game_pkg::*;
#(
  parameter int unsigned RX = 0,
  parameter int unsigned RY = 0,
  parameter int unsigned RW = 1,
  parameter int unsigned RH = 1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [POS_W-1:0] i_xpos,
  input  logic [POS_W-1:0] i_ypos,
  input  logic             i_left,
  output logic             o_click_c
);

  localparam logic [POS_W-1:0] X_LO = POS_W'(RX);
  localparam logic [POS_W-1:0] X_HI = POS_W'(RX + RW);
  localparam logic [POS_W-1:0] Y_LO = POS_W'(RY);
  localparam logic [POS_W-1:0] Y_HI = POS_W'(RY + RH);

  logic r_left_d;
  logic w_inside;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) r_left_d <= 1'b0;
    else      r_left_d <= i_left;
  end

  assign w_inside  = (i_xpos >= X_LO) && (i_xpos < X_HI) &&
                     (i_ypos >= Y_LO) && (i_ypos < Y_HI);
  assign o_click_c = i_left & ~r_left_d & w_inside;

endmodule

// File: rtl/game_ctl.sv
// Game-flow sequencer: IDLE -> WAIT -> GAME -> SCORE, round timer, score and text-box placement.
module game_ctl
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 40_000_000,
  parameter int unsigned GAME_SECONDS = 30,
  parameter int unsigned BTN_X        = 360,
  parameter int unsigned BTN_Y        = 192,
  parameter int unsigned BTN_W        = 128,
  parameter int unsigned BTN_H        = 64,
  parameter int unsigned STOP_X       = 700,
  parameter int unsigned STOP_Y       = 16,
  parameter int unsigned STOP_W       = 80,
  parameter int unsigned STOP_H       = 32
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [POS_W-1:0]   mouse_xpos,
  input  logic [POS_W-1:0]   mouse_ypos,
  input  logic               mouse_left,
  input  logic               uart_start,
  input  logic               target_hit,
  output logic [1:0]         state,
  output logic               game_active,
  output logic               uart_ready,
  output logic [SEC_W-1:0]   seconds_left,
  output logic [SCORE_W-1:0] score,
  output logic               score_valid,
  output logic [POS_W-1:0]   width_start,
  output logic [POS_W-1:0]   height_start
);

  localparam int unsigned      PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0] SEC_INIT = SEC_W'(GAME_SECONDS);

  state_e             r_state;
  logic               r_game_active;
  logic               r_uart_ready;
  logic               r_score_valid;
  logic               r_peer_rdy;
  logic [SEC_W-1:0]   r_seconds;
  logic [SCORE_W-1:0] r_score;
  logic [PRE_W-1:0]   r_presc;
  logic [POS_W-1:0]   r_box_x;
  logic [POS_W-1:0]   r_box_y;

  state_e             w_next;
  logic               w_start_clk;
  logic               w_stop_clk;
  logic               w_tc;
  logic               w_expire;
  logic               w_enter_game;
  logic               w_to_idle;
  logic [POS_W-1:0]   w_box_x;
  logic [POS_W-1:0]   w_box_y;

  region_click #(.RX(BTN_X), .RY(BTN_Y), .RW(BTN_W), .RH(BTN_H)) u_start_btn (
    .pclk      (pclk),
    .rst       (rst),
    .i_xpos    (mouse_xpos),
    .i_ypos    (mouse_ypos),
    .i_left    (mouse_left),
    .o_click_c (w_start_clk)
  );

  region_click #(.RX(STOP_X), .RY(STOP_Y), .RW(STOP_W), .RH(STOP_H)) u_stop_btn (
    .pclk      (pclk),
    .rst       (rst),
    .i_xpos    (mouse_xpos),
    .i_ypos    (mouse_ypos),
    .i_left    (mouse_left),
    .o_click_c (w_stop_clk)
  );

  assign w_tc         = (r_presc == PRE_TC);
  assign w_expire     = w_tc && (r_seconds == SEC_W'(1));
  assign w_enter_game = (w_next == ST_GAME) && (r_state != ST_GAME);
  assign w_to_idle    = (w_next == ST_IDLE) && (r_state != ST_IDLE);

  // Next state and the text-box placement that goes with it; stop beats expiry.
  always_comb begin
    w_next  = r_state;
    w_box_x = POS_W'(BTN_X);
    w_box_y = POS_W'(BTN_Y);
    case (r_state)
      ST_IDLE:  if (w_start_clk) w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_stop_clk)                     w_next = ST_IDLE;
        else if (r_peer_rdy || uart_start)  w_next = ST_GAME;
      end
      ST_GAME: begin
        if (w_stop_clk)    w_next = ST_IDLE;
        else if (w_expire) w_next = ST_SCORE;
      end
      ST_SCORE: if (w_start_clk) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    case (w_next)
      ST_GAME: begin
        w_box_x = POS_W'(STOP_X);
        w_box_y = POS_W'(STOP_Y);
      end
      ST_SCORE: begin
        w_box_x = SCORE_BOX_X;
        w_box_y = SCORE_BOX_Y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_game_active <= 1'b0;
      r_uart_ready  <= 1'b0;
      r_score_valid <= 1'b0;
      r_peer_rdy    <= 1'b0;
      r_seconds     <= '0;
      r_score       <= '0;
      r_presc       <= '0;
      r_box_x       <= POS_W'(BTN_X);
      r_box_y       <= POS_W'(BTN_Y);
    end else begin
      r_state       <= w_next;
      r_game_active <= (w_next == ST_GAME);
      r_uart_ready  <= (w_next == ST_WAIT);
      r_score_valid <= (w_next == ST_SCORE) && (r_state != ST_SCORE);
      r_box_x       <= w_box_x;
      r_box_y       <= w_box_y;

      // A ready pulse that moves WAIT to GAME is consumed, not latched.
      if (w_to_idle || w_enter_game)             r_peer_rdy <= 1'b0;
      else if (uart_start && r_state != ST_GAME) r_peer_rdy <= 1'b1;

      if (w_enter_game) begin
        r_score   <= '0;
        r_seconds <= SEC_INIT;
        r_presc   <= '0;
      end else if (r_state == ST_GAME) begin
        if (w_stop_clk) begin
          r_score <= '0;
        end else begin
          r_presc <= w_tc ? '0 : r_presc + PRE_W'(1);
          if (w_tc && r_seconds != '0) r_seconds <= r_seconds - SEC_W'(1);
          if (target_hit)              r_score   <= sat_inc(r_score);
        end
      end
    end
  end

  assign state        = r_state;
  assign game_active  = r_game_active;
  assign uart_ready   = r_uart_ready;
  assign score_valid  = r_score_valid;
  assign seconds_left = r_seconds;
  assign score        = r_score;
  assign width_start  = r_box_x;
  assign height_start = r_box_y;

endmodule

// File: tb/tb_game_ctl.sv
// Self-checking bench for game_ctl: cycle model plus directed literal checks.
module tb_game_ctl;

  localparam int CLK_HZ = 10;
  localparam int GS     = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic        mouse_left = 1'b0;
  logic        uart_start = 1'b0;
  logic        target_hit = 1'b0;
  logic [1:0]  state;
  logic        game_active;
  logic        uart_ready;
  logic [7:0]  seconds_left;
  logic [9:0]  score;
  logic        score_valid;
  logic [11:0] width_start;
  logic [11:0] height_start;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  game_ctl #(.CLK_HZ(CLK_HZ), .GAME_SECONDS(GS)) dut (
    .pclk         (clk),
    .rst          (rst),
    .mouse_xpos   (mouse_xpos),
    .mouse_ypos   (mouse_ypos),
    .mouse_left   (mouse_left),
    .uart_start   (uart_start),
    .target_hit   (target_hit),
    .state        (state),
    .game_active  (game_active),
    .uart_ready   (uart_ready),
    .seconds_left (seconds_left),
    .score        (score),
    .score_valid  (score_valid),
    .width_start  (width_start),
    .height_start (height_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_rect(input int x, input int y, input int rx, input int ry,
                                 input int rw, input int rh);
    return (x >= rx) && (x < rx + rw) && (y >= ry) && (y < ry + rh);
  endfunction

  function automatic int box_x(input int s);
    case (s)
      2: return 700;
      3: return 380;
      default: return 360;
    endcase
  endfunction

  function automatic int box_y(input int s);
    case (s)
      2: return 16;
      3: return 186;
      default: return 192;
    endcase
  endfunction

  // Behavioural model: round progress kept as elapsed cycles, seconds derived by division.
  int m_st, m_score, m_sec, m_el;
  bit m_sec_ok, m_peer, m_prev, m_sv;

  always @(posedge clk or negedge rst) begin
    int  nxt;
    bit  ev, s_clk, p_clk;
    if (!rst) begin
      m_st = 0; m_score = 0; m_sec = 0; m_el = 0;
      m_sec_ok = 1; m_peer = 0; m_prev = 0; m_sv = 0;
    end else begin
      ev     = mouse_left && !m_prev;
      m_prev = mouse_left;
      s_clk  = ev && in_rect(int'(mouse_xpos), int'(mouse_ypos), 360, 192, 128, 64);
      p_clk  = ev && in_rect(int'(mouse_xpos), int'(mouse_ypos), 700, 16, 80, 32);
      nxt    = m_st;
      case (m_st)
        0: if (s_clk) nxt = 1;
        1: if (p_clk) nxt = 0; else if (m_peer || uart_start) nxt = 2;
        2: begin
          if (p_clk) begin
            nxt = 0; m_score = 0; m_sec_ok = 0;
          end else begin
            if (target_hit) m_score = (m_score < 999) ? m_score + 1 : 999;
            m_el++;
            m_sec = GS - m_el / CLK_HZ;
            if (m_el == GS * CLK_HZ) nxt = 3;
          end
        end
        default: if (s_clk) nxt = 0;
      endcase
      if (nxt == 2 && m_st != 2) begin
        m_score = 0; m_el = 0; m_sec = GS; m_sec_ok = 1;
      end
      if ((nxt == 0 && m_st != 0) || (nxt == 2 && m_st != 2)) m_peer = 0;
      else if (uart_start && m_st != 2) m_peer = 1;
      m_sv = (nxt == 3 && m_st != 3);
      m_st = nxt;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk("state", int'(state), m_st);
      chk("game_active", int'(game_active), int'(m_st == 2));
      chk("uart_ready", int'(uart_ready), int'(m_st == 1));
      chk("score", int'(score), m_score);
      chk("score_valid", int'(score_valid), int'(m_sv));
      chk("width_start", int'(width_start), box_x(m_st));
      chk("height_start", int'(height_start), box_y(m_st));
      if (m_sec_ok) chk("seconds_left", int'(seconds_left), m_sec);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_game_active"}, int'(game_active), 0);
    chk({tag, "_uart_ready"}, int'(uart_ready), 0);
    chk({tag, "_seconds"}, int'(seconds_left), 0);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_score_valid"}, int'(score_valid), 0);
    chk({tag, "_width"}, int'(width_start), 360);
    chk({tag, "_height"}, int'(height_start), 192);
  endtask

  initial begin
    int cnt;
    #1 rst = 1'b0;
    tick(2);
    chk_reset_vals("reset");
    rst = 1'b1;
    chk_en = 1'b1;
    tick(2);

    // Basic round: start click, peer ready, full round with five hits.
    mouse_xpos = 12'd400; mouse_ypos = 12'd200; mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    chk("basic_wait_state", int'(state), 1);
    chk("basic_uart_ready", int'(uart_ready), 1);
    tick(1);
    uart_start = 1'b1;
    tick(1);
    uart_start = 1'b0;
    chk("basic_game_state", int'(state), 2);
    chk("basic_seconds", int'(seconds_left), GS);
    chk("basic_game_box_x", int'(width_start), 700);
    cnt = 0;
    while (state != 2'd3 && cnt < 1300) begin
      target_hit = (cnt < 5);
      tick(1);
      target_hit = 1'b0;
      cnt++;
    end
    chk("round_length", cnt, 1200);
    chk("expiry_score", int'(score), 5);
    chk("expiry_score_valid", int'(score_valid), 1);
    chk("expiry_seconds", int'(seconds_left), 0);
    chk("score_box_x", int'(width_start), 380);
    chk("score_box_y", int'(height_start), 186);
    target_hit = 1'b1;
    tick(1);
    target_hit = 1'b0;
    chk("score_valid_single", int'(score_valid), 0);
    chk("score_hold", int'(score), 5);

    // SCORE exit keeps the score.
    mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    chk("score_exit_state", int'(state), 0);
    chk("score_exit_keeps", int'(score), 5);
    tick(1);

    // Early peer ready: latched in IDLE, WAIT lasts one cycle.
    uart_start = 1'b1;
    tick(1);
    uart_start = 1'b0;
    chk("early_still_idle", int'(state), 0);
    mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    chk("early_wait", int'(state), 1);
    tick(1);
    chk("early_game", int'(state), 2);
    chk("early_score_clear", int'(score), 0);

    // Stop click lands on the expiry edge: stop wins.
    target_hit = 1'b1;
    tick(1);
    target_hit = 1'b0;
    tick(1198);
    chk("pre_expiry_seconds", int'(seconds_left), 1);
    chk("pre_expiry_score", int'(score), 1);
    mouse_xpos = 12'd710; mouse_ypos = 12'd20; mouse_left = 1'b1; target_hit = 1'b1;
    tick(1);
    target_hit = 1'b0;
    chk("stop_wins_state", int'(state), 0);
    chk("stop_wins_score", int'(score), 0);
    chk("stop_wins_box_x", int'(width_start), 360);

    // A held button over the start region is not a new click.
    mouse_xpos = 12'd400; mouse_ypos = 12'd200;
    tick(3);
    chk("held_no_retrigger", int'(state), 0);
    mouse_left = 1'b0;
    tick(1);

    // Saturation: 1005 consecutive hits.
    mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    uart_start = 1'b1;
    tick(1);
    uart_start = 1'b0;
    chk("sat_game", int'(state), 2);
    target_hit = 1'b1;
    tick(1005);
    target_hit = 1'b0;
    chk("sat_score", int'(score), 999);
    chk("sat_seconds", int'(seconds_left), 20);

    // Reset mid-round takes effect without a clock edge.
    tick(75);
    chk("pre_reset_seconds", int'(seconds_left), 12);
    #2 rst = 1'b0;
    #1 chk_reset_vals("async_reset");
    tick(1);
    rst = 1'b1;
    tick(2);
    mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    chk("post_reset_click", int'(state), 1);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
